decode38_scan_ctrl: RTL and testbench

Sequencer that generates the 3-bit select driving the 3-8 LED decoder. It walks the select through 0..7 at a programmable rate in up, down or bounce order, or passes a manual switch value straight through. A single-step input allows push-button advancing. Outputs feed the decoder's sw input directly. tick and wrap are provided for status LEDs and bench synchronisation.

---
 rtl/decode38_scan_ctrl_if.sv | 30 +++
 rtl/decode38_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_decode38_scan_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/decode38_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : decode38_scan_ctrl_if
// Description : Control/status bundle between a scan sequencer and its
//               driver: run controls in, decoder select and status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode38_scan_ctrl_if;
  logic       en;
  logic [1:0] mode;
  logic       step;
  logic [2:0] manual_sel;
  logic [2:0] sel;
  logic       dir;
  logic       tick;
  logic       wrap;

  // Sequencer side
  modport slave (
    input  en, mode, step, manual_sel,
    output sel, dir, tick, wrap
  );

  // Controller / bench side
  modport master (
    output en, mode, step, manual_sel,
    input  sel, dir, tick, wrap
  );
endinterface
`default_nettype wire

// File: rtl/decode38_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decode38_scan_ctrl
// Description : Generates the 3-bit select for a 3-8 LED decoder. Walks the
//               select up, down or bouncing at a programmable rate, accepts
//               push-button single steps, or passes a manual value through.
// Revision    : 1.0 - initial release
// ============================================================================
module decode38_scan_ctrl #(
  parameter int CNT_DIV = 12000000,
  parameter int CNT_W   = 24
) (
  input  wire                   clk,
  input  wire                   rst,
  decode38_scan_ctrl_if.slave   bus
);

  localparam logic [1:0]       C_MODE_UP     = 2'b00;
  localparam logic [1:0]       C_MODE_DOWN   = 2'b01;
  localparam logic [1:0]       C_MODE_BOUNCE = 2'b10;
  localparam logic [1:0]       C_MODE_MANUAL = 2'b11;
  localparam logic [CNT_W-1:0] C_PSC_LAST    = CNT_W'(CNT_DIV - 1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_MAN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_psc;
  logic [CNT_W-1:0] w_psc_nxt;
  logic [2:0]       r_sel;
  logic [2:0]       w_sel_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             r_step_d;
  logic [1:0]       r_mode_d;
  logic             w_man_req;
  logic             w_step_edge;
  logic             w_mode_chg;
  logic             w_auto;
  logic             w_adv;

  assign w_man_req   = (bus.mode == C_MODE_MANUAL);
  assign w_step_edge = bus.step & ~r_step_d;
  assign w_mode_chg  = (bus.mode != r_mode_d);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_HOLD;
    else     r_state <= w_state_nxt;
  end

  // Next state from the live inputs, then prescaler and select update
  always_comb begin
    w_state_nxt = r_state;
    w_psc_nxt   = r_psc;
    w_sel_nxt   = r_sel;
    w_dir_nxt   = r_dir;
    w_tick_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_auto      = 1'b0;
    w_adv       = 1'b0;

    case (r_state)
      ST_HOLD: begin
        if (w_man_req)   w_state_nxt = ST_MAN;
        else if (bus.en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_man_req)    w_state_nxt = ST_MAN;
        else if (!bus.en) w_state_nxt = ST_HOLD;
      end
      ST_MAN: begin
        if (!w_man_req)  w_state_nxt = bus.en ? ST_RUN : ST_HOLD;
      end
      default: w_state_nxt = ST_HOLD;
    endcase

    // A mode change restarts the rate period so the first auto advance in
    // the new mode lands a full period later.
    if (w_mode_chg || (w_state_nxt == ST_MAN)) begin
      w_psc_nxt = '0;
    end else if (w_state_nxt == ST_RUN) begin
      if (r_psc == C_PSC_LAST) begin
        w_psc_nxt = '0;
        w_auto    = 1'b1;
      end else begin
        w_psc_nxt = r_psc + CNT_W'(1);
      end
    end

    // Auto and step requests in the same cycle merge into a single advance
    w_adv = (w_state_nxt != ST_MAN) && (w_auto || w_step_edge);

    if (w_state_nxt == ST_MAN) begin
      w_sel_nxt = bus.manual_sel;
    end else if (w_adv) begin
      w_tick_nxt = 1'b1;
      case (bus.mode)
        C_MODE_UP: begin
          w_sel_nxt  = r_sel + 3'd1;
          w_wrap_nxt = (r_sel == 3'd7);
          w_dir_nxt  = 1'b1;
        end
        C_MODE_DOWN: begin
          w_sel_nxt  = r_sel - 3'd1;
          w_wrap_nxt = (r_sel == 3'd0);
          w_dir_nxt  = 1'b0;
        end
        C_MODE_BOUNCE: begin
          if (r_dir) begin
            if (r_sel == 3'd7) begin
              w_sel_nxt  = 3'd6;
              w_dir_nxt  = 1'b0;
              w_wrap_nxt = 1'b1;
            end else begin
              w_sel_nxt  = r_sel + 3'd1;
            end
          end else begin
            if (r_sel == 3'd0) begin
              w_sel_nxt  = 3'd1;
              w_dir_nxt  = 1'b1;
              w_wrap_nxt = 1'b1;
            end else begin
              w_sel_nxt  = r_sel - 3'd1;
            end
          end
        end
        default: w_tick_nxt = 1'b0;
      endcase
    end
  end

  // Datapath registers; reset discards any pending prescaler count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc    <= '0;
      r_sel    <= 3'd0;
      r_dir    <= 1'b1;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
      r_step_d <= 1'b0;
      r_mode_d <= C_MODE_UP;
    end else begin
      r_psc    <= w_psc_nxt;
      r_sel    <= w_sel_nxt;
      r_dir    <= w_dir_nxt;
      r_tick   <= w_tick_nxt;
      r_wrap   <= w_wrap_nxt;
      r_step_d <= bus.step;
      r_mode_d <= bus.mode;
    end
  end

  assign bus.sel  = r_sel;
  assign bus.dir  = r_dir;
  assign bus.tick = r_tick;
  assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decode38_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode38_scan_ctrl
// Description : Directed bench for decode38_scan_ctrl with CNT_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode38_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  decode38_scan_ctrl_if bus ();

  decode38_scan_ctrl #(.CNT_DIV(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until a tick is seen; n returns the number of edges taken
  task automatic wait_tick(input int lim, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.tick && n < lim);
    if (!bus.tick) check("tick_timeout", 0, 1);
  endtask

  task automatic step_pulse();
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
    cyc();
  endtask

  int n;
  int ticks;
  int exp_bsel [10] = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int exp_bdir [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
  int exp_dsel [4]  = '{1, 0, 7, 6};

  initial begin
    bus.en = 1'b1;
    bus.mode = 2'b00;
    bus.step = 1'b0;
    bus.manual_sel = 3'd0;

    // 1: reset, then UP through a full lap
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_sel", bus.sel, 0);
    check("rst_dir", bus.dir, 1);
    check("rst_tick", bus.tick, 0);
    check("rst_wrap", bus.wrap, 0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wait_tick(20, n);
      check("up_space", n, 4);
      check("up_sel", bus.sel, i % 8);
      check("up_wrap", bus.wrap, (i == 8) ? 1 : 0);
      check("up_dir", bus.dir, 1);
    end

    // 2: step to sel=2 in HOLD, then DOWN
    bus.en = 1'b0;
    step_pulse();
    step_pulse();
    check("hold_step_sel", bus.sel, 2);
    bus.mode = 2'b01;
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick(20, n);
      check("dn_space", n, (i == 0) ? 5 : 4);
      check("dn_sel", bus.sel, exp_dsel[i]);
      check("dn_wrap", bus.wrap, (i == 2) ? 1 : 0);
      check("dn_dir", bus.dir, 0);
    end

    // Reach sel=5, dir=1 via MANUAL then one UP step
    bus.mode = 2'b11;
    bus.manual_sel = 3'd4;
    cyc();
    check("man_sel4", bus.sel, 4);
    check("man_dir_kept", bus.dir, 0);
    bus.mode = 2'b00;
    bus.en = 1'b0;
    cyc();
    step_pulse();
    check("pre_b_sel", bus.sel, 5);
    check("pre_b_dir", bus.dir, 1);

    // 3: BOUNCE from sel=5 going up
    bus.mode = 2'b10;
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_tick(20, n);
      check("bn_space", n, (i == 0) ? 5 : 4);
      check("bn_sel", bus.sel, exp_bsel[i]);
      check("bn_dir", bus.dir, exp_bdir[i]);
      check("bn_wrap", bus.wrap, (i == 2 || i == 9) ? 1 : 0);
    end

    // 4: HOLD, level step held high only advances once per rising edge
    bus.mode = 2'b00;
    bus.en = 1'b0;
    cyc();
    check("chg_no_adv", bus.tick, 0);
    step_pulse();
    step_pulse();
    check("st_sel3", bus.sel, 3);
    ticks = 0;
    bus.step = 1'b1;
    repeat (10) begin cyc(); ticks += int'(bus.tick); end
    bus.step = 1'b0;
    repeat (3) begin cyc(); ticks += int'(bus.tick); end
    bus.step = 1'b1;
    repeat (3) begin cyc(); ticks += int'(bus.tick); end
    check("st_ticks", ticks, 2);
    check("st_sel5", bus.sel, 5);
    bus.step = 1'b0;
    cyc();

    // 5: step rising on the auto-advance edge gives one advance
    bus.en = 1'b1;
    repeat (3) cyc();
    check("co_pre_tick", bus.tick, 0);
    bus.step = 1'b1;
    cyc();
    check("co_sel", bus.sel, 6);
    check("co_tick", bus.tick, 1);
    cyc();
    check("co_sel_after", bus.sel, 6);
    check("co_tick_after", bus.tick, 0);
    bus.step = 1'b0;
    bus.mode = 2'b11;
    bus.manual_sel = 3'd2;
    cyc();
    check("man_sel2", bus.sel, 2);
    bus.manual_sel = 3'd6;
    cyc();
    check("man_sel6", bus.sel, 6);
    bus.step = 1'b1;
    cyc();
    check("man_step_sel", bus.sel, 6);
    check("man_step_tick", bus.tick, 0);
    cyc();
    bus.step = 1'b0;
    cyc();
    bus.mode = 2'b00;
    wait_tick(20, n);
    check("man_exit_space", n, 5);
    check("man_exit_sel", bus.sel, 7);

    // 6: reset mid-count (prescaler=2, sel=4, dir=0)
    bus.mode = 2'b01;
    wait_tick(20, n);
    wait_tick(20, n);
    wait_tick(20, n);
    check("r6_pre_sel", bus.sel, 4);
    check("r6_pre_dir", bus.dir, 0);
    cyc();
    cyc();
    rst = 1'b1;
    bus.mode = 2'b00;
    cyc();
    check("r6_sel", bus.sel, 0);
    check("r6_dir", bus.dir, 1);
    check("r6_tick", bus.tick, 0);
    rst = 1'b0;
    wait_tick(20, n);
    check("r6_space", n, 4);
    check("r6_sel_after", bus.sel, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
